iir_coeff_loader: RTL and testbench
===================================

IIR_COEFF_LOADER -- requirements
Module: iir_coeff_loader

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 255, meaning the maximum idle cycles allowed between words of one frame.
REQ-002 SHALL have parameter DEF_B0, default 16'h7FFF, meaning the reset value of coeff_b0 (Q1.15, ~1.0 pass-through).
REQ-003 SHALL have clk  input  1  the single clock; all logic is on the rising edge.
REQ-004 SHALL have rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have cfg_valid  input  1  word-stream valid.
REQ-006 SHALL have cfg_ready  output  1  word-stream ready.
REQ-007 SHALL have cfg_data  input  16  coefficient word, Q1.15 two's complement.
REQ-008 SHALL have cfg_last  input  1  marks the final word of a frame.
REQ-009 SHALL have sample_tick  input  1  pulse marking the filter sample boundary, when a commit is allowed.
REQ-010 SHALL have coeff_b0, coeff_b1, coeff_b2, coeff_a1, coeff_a2  output  16 each  active coefficients driving the downstream IIR stage.
REQ-011 SHALL have coeff_update  output  1  one-cycle pulse when the active set changes.
REQ-012 SHALL have cfg_err  output  1  one-cycle pulse when a frame is rejected.
REQ-013 SHALL have cfg_err_code  output  2  error cause, held until the next error: 01 early last, 10 missing last, 11 timeout.
REQ-014 SHALL have busy  output  1  high while in LOAD or PENDING.

Function
REQ-015 SHALL transfer a word on any cycle where cfg_valid && cfg_ready.
REQ-016 SHALL accept a frame of exactly 5 words in the fixed order b0, b1, b2, a1, a2, writing them into shadow registers by word index 0..4.
REQ-017 SHALL implement states IDLE, LOAD and PENDING.
REQ-018 SHALL, in IDLE, on a transfer, store the word at index 0 and go to LOAD with index 1; cfg_last on that word raises an error (code 01).
REQ-019 SHALL, in LOAD, on a transfer at index < 4 with cfg_last=1, raise an error (code 01).
REQ-020 SHALL, in LOAD, on a transfer at index 4, store the word; with cfg_last=1 it goes to PENDING, with cfg_last=0 it raises an error (code 10).
REQ-021 SHALL, in LOAD, count cycles without a transfer, clear the count on each transfer, and raise an error (code 11) when the count reaches TIMEOUT_CYC.
REQ-022 SHALL, on any error: pulse cfg_err for 1 cycle, update cfg_err_code, discard the shadow frame, return to IDLE, and leave the active coefficients unchanged.
REQ-023 SHALL drive cfg_ready = 1 in IDLE and LOAD and 0 in PENDING; cfg_ready is decoded from state only and never depends on cfg_valid.
REQ-024 SHALL, in PENDING, ignore any sample_tick in the same cycle the state was entered; on the first later sample_tick it copies all 5 shadow words to the active outputs in one cycle, pulses coeff_update on the following cycle together with the new values, and returns to IDLE.
REQ-025 SHALL never change the active outputs except at a commit (REQ-024) or reset, so the IIR stage never sees a partial set.
REQ-026 SHALL treat cfg_data as opaque: no arithmetic, saturation or range check.
REQ-027 SHALL have no combinational path from cfg_data to the coeff_* outputs.

Reset
REQ-028 SHALL, on rst, immediately set state=IDLE, index=0, timeout count=0, shadow registers=0, coeff_b0=DEF_B0, all other coeff_*=0, coeff_update=0, cfg_err=0, cfg_err_code=00, busy=0, cfg_ready=1.
REQ-029 SHALL, on rst asserted mid-frame or in PENDING, discard the pending frame and not commit it after reset is released.

Structure
REQ-030 SHALL place the state enum, word-index constants (IDX_B0..IDX_A2), error-code constants and default-coefficient constants in the shared package iir_pkg.
REQ-031 SHALL be a single module with no sub-modules; the timeout counter is inline.

Verification
REQ-032 Good frame 1000,2000,1000,C000,4000 with last on word 5, then sample_tick 3 cycles later -> outputs update exactly once, coeff_update pulses once, and busy falls.
REQ-033 cfg_last on word 3 -> cfg_err pulse, code 01, outputs remain at reset defaults (b0=7FFF); a following good frame commits normally.
REQ-034 Five words with no last -> code 10; a 6th word sent immediately afterwards is accepted as index 0 of a new frame.
REQ-035 Two words then idle with TIMEOUT_CYC=8 -> cfg_err exactly 8 idle cycles after the 2nd word, code 11.
REQ-036 sample_tick held high throughout a frame -> commit occurs on the cycle after PENDING is entered, not on the entry cycle; cfg_ready=0 in PENDING with cfg_valid=1 -> no word consumed.
REQ-037 rst asserted while in PENDING -> outputs at defaults after reset and no coeff_update on later sample_tick pulses.

Source files
------------

// File: rtl/iir_pkg.sv
// Shared types and constants for the IIR coefficient loader.
package iir_pkg;

    // Loader control states
    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StPending
    } state_t;

    // Number of coefficient words in one frame
    localparam int unsigned NUM_WORDS = 5;

    // Word index of each coefficient within a frame
    localparam logic [2:0] IDX_B0 = 3'd0;
    localparam logic [2:0] IDX_B1 = 3'd1;
    localparam logic [2:0] IDX_B2 = 3'd2;
    localparam logic [2:0] IDX_A1 = 3'd3;
    localparam logic [2:0] IDX_A2 = 3'd4;

    // Error cause codes reported on cfg_err_code
    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_EARLY   = 2'b01;
    localparam logic [1:0] ERR_MISSING = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT = 2'b11;

    // Power-on coefficient values: b0 ~1.0 in Q1.15, everything else zero
    localparam logic [15:0] DEF_B0_Q15 = 16'h7FFF;
    localparam logic [15:0] DEF_COEFF  = 16'h0000;

endpackage

// File: rtl/iir_coeff_loader.sv
// Receives 5-word coefficient frames (b0,b1,b2,a1,a2) into shadow registers and
// commits the whole set atomically to the active outputs on a sample boundary.
module iir_coeff_loader
    import iir_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 255,
    parameter logic [15:0] DEF_B0      = DEF_B0_Q15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cfg_valid,
    output logic        cfg_ready,
    input  logic [15:0] cfg_data,
    input  logic        cfg_last,
    input  logic        sample_tick,
    output logic [15:0] coeff_b0,
    output logic [15:0] coeff_b1,
    output logic [15:0] coeff_b2,
    output logic [15:0] coeff_a1,
    output logic [15:0] coeff_a2,
    output logic        coeff_update,
    output logic        cfg_err,
    output logic [1:0]  cfg_err_code,
    output logic        busy
);

    localparam int unsigned CNT_W = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    state_t           state_q, state_d;
    logic [2:0]       idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             armed_q, armed_d;   // PENDING has lasted past its entry cycle
    logic             err_q, err_d;
    logic [1:0]       code_q, code_d;
    logic             upd_q;
    logic             wr_en;
    logic             commit;
    logic             xfer;

    logic [15:0] shadow_q [NUM_WORDS];
    logic [15:0] active_q [NUM_WORDS];

    assign cfg_ready = (state_q != StPending);
    assign busy      = (state_q != StIdle);
    assign xfer      = cfg_valid && cfg_ready;

    // Next-state, word sequencing, timeout and error decode
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        armed_d = armed_q;
        err_d   = 1'b0;
        code_d  = code_q;
        wr_en   = 1'b0;
        commit  = 1'b0;
        case (state_q)
            StIdle: begin
                idx_d = IDX_B0;
                cnt_d = '0;
                if (xfer) begin
                    wr_en = 1'b1;
                    if (cfg_last) begin
                        err_d  = 1'b1;
                        code_d = ERR_EARLY;
                    end else begin
                        state_d = StLoad;
                        idx_d   = IDX_B1;
                    end
                end
            end
            StLoad: begin
                if (xfer) begin
                    wr_en = 1'b1;
                    cnt_d = '0;
                    if (idx_q == IDX_A2) begin
                        if (cfg_last) begin
                            state_d = StPending;
                            armed_d = 1'b0;
                        end else begin
                            err_d  = 1'b1;
                            code_d = ERR_MISSING;
                        end
                    end else if (cfg_last) begin
                        err_d  = 1'b1;
                        code_d = ERR_EARLY;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    err_d  = 1'b1;
                    code_d = ERR_TIMEOUT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
                // Any error abandons the frame; shadow contents are simply overwritten later
                if (err_d) begin
                    state_d = StIdle;
                    idx_d   = IDX_B0;
                    cnt_d   = '0;
                end
            end
            StPending: begin
                armed_d = 1'b1;
                if (armed_q && sample_tick) begin
                    commit  = 1'b1;
                    state_d = StIdle;
                    idx_d   = IDX_B0;
                end
            end
            default: begin
                state_d = StIdle;
                idx_d   = IDX_B0;
                cnt_d   = '0;
            end
        endcase
    end

    // Control state and status registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            idx_q   <= IDX_B0;
            cnt_q   <= '0;
            armed_q <= 1'b0;
            err_q   <= 1'b0;
            code_q  <= ERR_NONE;
            upd_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            armed_q <= armed_d;
            err_q   <= err_d;
            code_q  <= code_d;
            upd_q   <= commit;
        end
    end

    // Shadow frame capture by word index
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_WORDS; i++) begin
                shadow_q[i] <= DEF_COEFF;
            end
        end else if (wr_en) begin
            shadow_q[idx_q] <= cfg_data;
        end
    end

    // Active set changes only as a whole, on commit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active_q[IDX_B0] <= DEF_B0;
            for (int i = 1; i < NUM_WORDS; i++) begin
                active_q[i] <= DEF_COEFF;
            end
        end else if (commit) begin
            for (int i = 0; i < NUM_WORDS; i++) begin
                active_q[i] <= shadow_q[i];
            end
        end
    end

    assign coeff_b0     = active_q[IDX_B0];
    assign coeff_b1     = active_q[IDX_B1];
    assign coeff_b2     = active_q[IDX_B2];
    assign coeff_a1     = active_q[IDX_A1];
    assign coeff_a2     = active_q[IDX_A2];
    assign coeff_update = upd_q;
    assign cfg_err      = err_q;
    assign cfg_err_code = code_q;

endmodule

// File: tb/tb_iir_coeff_loader.sv
// Self-checking bench for iir_coeff_loader: directed scenarios plus random
// traffic, all checked cycle by cycle against a frame-level reference model.
module tb_iir_coeff_loader;

    localparam int unsigned TMO = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [15:0] cfg_data;
    logic        cfg_last;
    logic        sample_tick;
    logic [15:0] coeff_b0, coeff_b1, coeff_b2, coeff_a1, coeff_a2;
    logic        coeff_update;
    logic        cfg_err;
    logic [1:0]  cfg_err_code;
    logic        busy;

    int n_total = 0;
    int n_bad   = 0;
    int upd_seen = 0;
    int err_seen = 0;

    // Reference model: words of the frame in progress, a pending flag, and the active set
    logic [15:0] m_frame[$];
    bit          m_pend;
    int          m_age;
    int          m_idle;
    logic [15:0] m_act[5];
    bit          m_upd;
    bit          m_err;
    logic [1:0]  m_code;

    iir_coeff_loader #(
        .TIMEOUT_CYC(TMO),
        .DEF_B0     (16'h7FFF)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_data    (cfg_data),
        .cfg_last    (cfg_last),
        .sample_tick (sample_tick),
        .coeff_b0    (coeff_b0),
        .coeff_b1    (coeff_b1),
        .coeff_b2    (coeff_b2),
        .coeff_a1    (coeff_a1),
        .coeff_a2    (coeff_a2),
        .coeff_update(coeff_update),
        .cfg_err     (cfg_err),
        .cfg_err_code(cfg_err_code),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_frame.delete();
        m_pend = 0;
        m_age  = 0;
        m_idle = 0;
        m_act[0] = 16'h7FFF;
        for (int i = 1; i < 5; i++) m_act[i] = 16'h0000;
        m_upd  = 0;
        m_err  = 0;
        m_code = 2'b00;
    endfunction

    // One clock of the frame rules, using the inputs present at the edge
    function automatic void model_step(input bit v, input logic [15:0] d, input bit l,
                                       input bit t);
        m_upd = 0;
        m_err = 0;
        if (m_pend) begin
            if (m_age > 0 && t) begin
                for (int i = 0; i < 5; i++) m_act[i] = m_frame[i];
                m_frame.delete();
                m_pend = 0;
                m_upd  = 1;
            end else begin
                m_age++;
            end
        end else if (v) begin
            m_frame.push_back(d);
            m_idle = 0;
            if (m_frame.size() == 5) begin
                if (l) begin
                    m_pend = 1;
                    m_age  = 0;
                end else begin
                    m_err = 1; m_code = 2'b10; m_frame.delete();
                end
            end else if (l) begin
                m_err = 1; m_code = 2'b01; m_frame.delete();
            end
        end else if (m_frame.size() > 0) begin
            m_idle++;
            if (m_idle == TMO) begin
                m_err = 1; m_code = 2'b11; m_frame.delete(); m_idle = 0;
            end
        end
    endfunction

    task automatic check_all();
        check_eq("ready",  32'(cfg_ready),    32'(!m_pend));
        check_eq("busy",   32'(busy),         32'(m_pend || m_frame.size() > 0));
        check_eq("b0",     32'(coeff_b0),     32'(m_act[0]));
        check_eq("b1",     32'(coeff_b1),     32'(m_act[1]));
        check_eq("b2",     32'(coeff_b2),     32'(m_act[2]));
        check_eq("a1",     32'(coeff_a1),     32'(m_act[3]));
        check_eq("a2",     32'(coeff_a2),     32'(m_act[4]));
        check_eq("update", 32'(coeff_update), 32'(m_upd));
        check_eq("err",    32'(cfg_err),      32'(m_err));
        check_eq("code",   32'(cfg_err_code), 32'(m_code));
        if (coeff_update === 1'b1) upd_seen++;
        if (cfg_err === 1'b1) err_seen++;
    endtask

    // Called at a negedge: apply inputs, clock once, check at the next negedge
    task automatic cycle(input bit v, input logic [15:0] d, input bit l, input bit t);
        cfg_valid   = v;
        cfg_data    = d;
        cfg_last    = l;
        sample_tick = t;
        @(posedge clk);
        model_step(v, d, l, t);
        @(negedge clk);
        check_all();
    endtask

    task automatic do_reset();
        cfg_valid = 0; cfg_data = '0; cfg_last = 0; sample_tick = 0;
        rst = 1'b1;
        model_reset();
        #1;
        check_all();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_all();
    endtask

    task automatic send_frame(input logic [15:0] w0, input logic [15:0] w1,
                              input logic [15:0] w2, input logic [15:0] w3,
                              input logic [15:0] w4, input bit t);
        cycle(1, w0, 0, t);
        cycle(1, w1, 0, t);
        cycle(1, w2, 0, t);
        cycle(1, w3, 0, t);
        cycle(1, w4, 1, t);
    endtask

    int k;
    int base;

    initial begin
        rst = 1'b1;
        cfg_valid = 0; cfg_data = '0; cfg_last = 0; sample_tick = 0;
        model_reset();
        @(negedge clk);
        check_all();
        check_eq("rst_b0", 32'(coeff_b0), 32'h7FFF);
        rst = 1'b0;
        cycle(0, 16'h0, 0, 1);

        // Good frame, tick three cycles after the last word
        base = upd_seen;
        send_frame(16'h1000, 16'h2000, 16'h1000, 16'hC000, 16'h4000, 0);
        cycle(0, 16'h0, 0, 0);
        cycle(0, 16'h0, 0, 0);
        cycle(0, 16'h0, 0, 1);
        for (int i = 0; i < 4; i++) cycle(0, 16'h0, 0, i[0]);
        check_eq("good_upd_once", 32'(upd_seen - base), 32'd1);
        check_eq("good_a1", 32'(coeff_a1), 32'hC000);
        check_eq("good_busy", 32'(busy), 32'd0);

        // Early last on the third word
        do_reset();
        base = err_seen;
        cycle(1, 16'h1111, 0, 0);
        cycle(1, 16'h2222, 0, 0);
        cycle(1, 16'h3333, 1, 0);
        check_eq("early_code", 32'(cfg_err_code), 32'd1);
        check_eq("early_b0", 32'(coeff_b0), 32'h7FFF);
        check_eq("early_err_once", 32'(err_seen - base), 32'd1);
        send_frame(16'hA001, 16'hA002, 16'hA003, 16'hA004, 16'hA005, 0);
        cycle(0, 16'h0, 0, 0);
        cycle(0, 16'h0, 0, 1);
        cycle(0, 16'h0, 0, 0);
        check_eq("early_then_good", 32'(coeff_a2), 32'hA005);

        // Five words without last, then a sixth word starts a new frame
        cycle(1, 16'h0101, 0, 0);
        cycle(1, 16'h0202, 0, 0);
        cycle(1, 16'h0303, 0, 0);
        cycle(1, 16'h0404, 0, 0);
        cycle(1, 16'h0505, 0, 0);
        check_eq("missing_code", 32'(cfg_err_code), 32'd2);
        cycle(1, 16'h0606, 0, 0);
        check_eq("sixth_busy", 32'(busy), 32'd1);
        for (int i = 0; i < 12; i++) cycle(0, 16'h0, 0, 0);

        // Timeout after two words
        do_reset();
        cycle(1, 16'h1234, 0, 0);
        cycle(1, 16'h5678, 0, 0);
        k = 0;
        while (k < 20) begin
            cycle(0, 16'h0, 0, 0);
            k++;
            if (cfg_err === 1'b1) break;
        end
        check_eq("timeout_cycles", 32'(k), 32'(TMO));
        check_eq("timeout_code", 32'(cfg_err_code), 32'd3);

        // Tick held high throughout; words offered while pending are refused
        base = upd_seen;
        send_frame(16'h0011, 16'h0022, 16'h0033, 16'h0044, 16'h0055, 1);
        check_eq("pend_ready", 32'(cfg_ready), 32'd0);
        check_eq("pend_no_commit_entry", 32'(coeff_b0), 32'h7FFF);
        cycle(1, 16'hDEAD, 0, 1);
        cycle(0, 16'h0, 0, 1);
        check_eq("held_tick_b0", 32'(coeff_b0), 32'h0011);
        check_eq("held_tick_upd", 32'(upd_seen - base), 32'd1);
        check_eq("refused_word_busy", 32'(busy), 32'd0);

        // Reset while pending discards the frame
        send_frame(16'h0F0F, 16'h0E0E, 16'h0D0D, 16'h0C0C, 16'h0B0B, 0);
        do_reset();
        base = upd_seen;
        for (int i = 0; i < 6; i++) cycle(0, 16'h0, 0, 1);
        check_eq("rst_pend_no_upd", 32'(upd_seen - base), 32'd0);
        check_eq("rst_pend_b1", 32'(coeff_b1), 32'h0000);

        // Random traffic
        for (int n = 0; n < 2500; n++) begin
            bit v, l, t;
            logic [15:0] d;
            if ($urandom_range(0, 599) == 0) begin
                do_reset();
            end else if ($urandom_range(0, 39) == 0) begin
                int gap = $urandom_range(4, 11);
                for (int g = 0; g < gap; g++) cycle(0, 16'h0, 0, ($urandom_range(0, 3) == 0));
            end else begin
                v = ($urandom_range(0, 9) < 7);
                d = 16'($urandom);
                if (m_frame.size() == 4) l = ($urandom_range(0, 7) != 0);
                else l = ($urandom_range(0, 11) == 0);
                t = ($urandom_range(0, 3) == 0);
                cycle(v, d, l, t);
            end
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
